// File: rtl/parking_display.sv
// rtl/parking_display.sv - four-digit occupancy display with full/empty LEDs and entry-while-full alarm
//
// Purpose:
//   Shows "P", the current occupancy, "-" and the number of free spaces on a
//   multiplexed active-low 7-segment display. Blinks full_led while the lot is
//   full and raises a timed alarm when a car enters a full lot.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-low reset
//   count      occupancy from the car counter stage
//   carIn      one-cycle car entry pulse
//   seg        segment drive {g,f,e,d,c,b,a}, active-low
//   an         digit enables, active-low one-hot, an[3] leftmost
//   full_led   blinks while the lot is full
//   empty_led  steady high while the lot is empty
//   alarm      high while the entry-while-full alarm is active

module parking_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000,
    parameter int CAPACITY    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] count,
    input  logic       carIn,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       full_led,
    output logic       empty_led,
    output logic       alarm
);

    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [2:0]    CAP3       = 3'(CAPACITY);

    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_IDLE,
        ST_ALARM
    } state_t;

    function automatic logic [6:0] glyph(input logic [2:0] v);
        logic [6:0] g;
        case (v)
            3'd0:    g = 7'h40;
            3'd1:    g = 7'h79;
            3'd2:    g = 7'h24;
            3'd3:    g = 7'h30;
            3'd4:    g = 7'h19;
            3'd5:    g = 7'h12;
            3'd6:    g = 7'h02;
            default: g = 7'h78;
        endcase
        return g;
    endfunction

    logic [2:0]    cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    state_t        state_q, state_d;
    logic [2:0]    left_q, left_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          full_led_q, full_led_d;
    logic          alarm_q, alarm_d;

    logic          ref_tc;
    logic          blink_tc;
    logic [2:0]    free_cnt;

    always_comb begin
        cnt_d   = count;
        full_d  = (cnt_q >= CAP3);
        empty_d = (cnt_q == 3'd0);

        // Occupancy above capacity reads as zero free spaces.
        free_cnt = (cnt_q >= CAP3) ? 3'd0 : (CAP3 - cnt_q);

        ref_tc    = (ref_cnt_q == REF_LAST);
        ref_cnt_d = ref_tc ? '0 : ref_cnt_q + 1'b1;
        // 2-bit index wraps naturally 0 -> 3.
        dig_d     = ref_tc ? dig_q - 2'd1 : dig_q;

        blink_tc    = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d = blink_tc ? '0 : blink_cnt_q + 1'b1;
        blink_d     = blink_q ^ blink_tc;

        // The digit shown is the one selected before this edge, so an and seg
        // always describe the same digit.
        an_d = ~(4'b0001 << dig_q);
        case (dig_q)
            2'd3:    seg_d = SEG_P;
            2'd2:    seg_d = glyph(cnt_q);
            2'd1:    seg_d = SEG_DASH;
            default: begin
                if (state_q == ST_ALARM && blink_q) begin
                    seg_d = SEG_BLANK;
                end else if (full_q) begin
                    seg_d = SEG_F;
                end else begin
                    seg_d = glyph(free_cnt);
                end
            end
        endcase

        // Entry decisions use the registered full flag, not the fresh compare.
        state_d = state_q;
        left_d  = left_q;
        case (state_q)
            ST_IDLE: begin
                if (carIn && full_q) begin
                    state_d = ST_ALARM;
                    left_d  = 3'd4;
                end
            end
            default: begin
                if (carIn && full_q) begin
                    left_d = 3'd4;
                end else if (blink_tc) begin
                    if (left_q <= 3'd1) begin
                        state_d = ST_IDLE;
                        left_d  = 3'd0;
                    end else begin
                        left_d = left_q - 3'd1;
                    end
                end
            end
        endcase

        alarm_d    = (state_d == ST_ALARM);
        full_led_d = full_d & blink_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= 3'd0;
            full_q      <= 1'b0;
            empty_q     <= 1'b0;
            ref_cnt_q   <= '0;
            dig_q       <= 2'd3;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            state_q     <= ST_IDLE;
            left_q      <= 3'd0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1111;
            full_led_q  <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            ref_cnt_q   <= ref_cnt_d;
            dig_q       <= dig_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            state_q     <= state_d;
            left_q      <= left_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            full_led_q  <= full_led_d;
            alarm_q     <= alarm_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign full_led  = full_led_q;
    assign empty_led = empty_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_parking_display.sv
// tb/tb_parking_display.sv - randomized self-checking bench for parking_display

module tb_parking_display;

    localparam int RD  = 4;
    localparam int BD  = 8;
    localparam int CAP = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] count = 3'd0;
    logic       carIn = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       full_led;
    logic       empty_led;
    logic       alarm;

    parking_display #(
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD),
        .CAPACITY    (CAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .carIn     (carIn),
        .seg       (seg),
        .an        (an),
        .full_led  (full_led),
        .empty_led (empty_led),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: edge number n since reset release, history-based.
    int         n;
    logic [2:0] m_cnt;
    bit         m_full;
    bit         m_empty;
    int         m_left;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    bit         exp_fl;

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] tbl [0:7];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        return tbl[v];
    endfunction

    task automatic model_reset();
        n       = 0;
        m_cnt   = 3'd0;
        m_full  = 0;
        m_empty = 0;
        m_left  = 0;
        exp_seg = 7'h7F;
        exp_an  = 4'b1111;
        exp_fl  = 0;
    endtask

    task automatic model_edge(input logic [2:0] c, input bit car);
        int d;
        int free_sp;
        bit ph_prev;
        n++;
        d       = 3 - (((n - 1) / RD) % 4);
        ph_prev = (((n - 1) / BD) % 2) == 1;
        free_sp = (int'(m_cnt) >= CAP) ? 0 : CAP - int'(m_cnt);
        case (d)
            3: exp_seg = 7'h0C;
            2: exp_seg = glyph(int'(m_cnt));
            1: exp_seg = 7'h3F;
            default: begin
                if (m_left > 0 && ph_prev) exp_seg = 7'h7F;
                else if (m_full)           exp_seg = 7'h0E;
                else                       exp_seg = glyph(free_sp);
            end
        endcase
        exp_an = 4'b1111 ^ (4'b0001 << d);
        if (car && m_full)               m_left = 4;
        else if (m_left > 0 && n % BD == 0) m_left--;
        m_full  = int'(m_cnt) >= CAP;
        m_empty = (m_cnt == 3'd0);
        m_cnt   = c;
        exp_fl  = m_full && ((n / BD) % 2 == 1);
    endtask

    task automatic check_all();
        check_eq($sformatf("seg@%0d", n),       32'(seg),       32'(exp_seg));
        check_eq($sformatf("an@%0d", n),        32'(an),        32'(exp_an));
        check_eq($sformatf("full_led@%0d", n),  32'(full_led),  32'(exp_fl));
        check_eq($sformatf("empty_led@%0d", n), 32'(empty_led), 32'(m_empty));
        check_eq($sformatf("alarm@%0d", n),     32'(alarm),     32'(m_left > 0));
    endtask

    task automatic step(input logic [2:0] c, input bit car);
        count = c;
        carIn = car;
        @(posedge clk);
        model_edge(c, car);
        @(negedge clk);
        carIn = 1'b0;
        check_all();
    endtask

    task automatic run(input logic [2:0] c, input int cycles);
        for (int i = 0; i < cycles; i++) step(c, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;

        // empty lot: full scan, empty_led on
        run(3'd0, 20);
        // partial occupancy
        run(3'd3, 20);
        // full lot, blink and alarm with a retrigger
        run(3'd7, 20);
        step(3'd7, 1'b1);
        run(3'd7, 18);
        step(3'd7, 1'b1);
        run(3'd7, 45);
        // not full: entry ignored
        run(3'd5, 3);
        step(3'd5, 1'b1);
        run(3'd5, 20);
        // entry in the cycle full deasserts uses the registered flag
        run(3'd7, 4);
        step(3'd0, 1'b1);
        run(3'd0, 40);

        // randomized occupancy and entries, biased towards a full lot
        for (int b = 0; b < 60; b++) begin
            logic [2:0] c;
            int len;
            c   = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) step(c, $urandom_range(0, 5) == 0);
        end

        // reset asserted mid-alarm acts without a clock edge
        run(3'd7, 3);
        step(3'd7, 1'b1);
        run(3'd7, 5);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b1;
        for (int i = 0; i < 150; i++) step(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
